// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the regfile_mp multi-port register file.
// Optional build macro: REGFILE_MP_BYPASS_EN (write-to-read forwarding).
package regfile_mp_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_ZERO_ADDR = 0;

    // LSB position of port `port` inside a packed bus of `width`-bit fields.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_clear.sv
// Post-reset clear sequencer: walks R[1]..R[NREGS-1] once, then reports ready.
// Optional build macro: REGFILE_MP_BYPASS_EN (not used in this file).
module regfile_mp_clear
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_addr_o,
    output rf_state_e     state_o
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_en_o = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_en_o = 1'b1;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) state_d = RF_READY;
            end
            RF_READY: state_d = RF_READY;
            default:  state_d = RF_CLEAR;
        endcase
    end

    assign clr_addr_o = cnt_q;
    assign ready_o    = (state_q == RF_READY);
    assign state_o    = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised write ports.
// Optional build macro: REGFILE_MP_BYPASS_EN forwards same-cycle writes to reads.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                wen0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                wen1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic                wdrop
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic            clr_en;
    logic [AW-1:0]   clr_addr;
    rf_state_e       state;
    logic            we0, we1;
    logic            wdrop_q, wdrop_d;

    regfile_mp_clear #(.NREGS(NREGS), .AW(AW)) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_o    (ready),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr),
        .state_o    (state)
    );

    assign we0 = rst_n && ready && wen0 && (waddr0 != AW'(RF_ZERO_ADDR));
    assign we1 = rst_n && ready && wen1 && (waddr1 != AW'(RF_ZERO_ADDR));

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst_n && clr_en) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (we0) mem_q[waddr0] <= wdata0;
            if (we1) mem_q[waddr1] <= wdata1;
        end
    end

    // Drops: anything non-zero during the sweep, or port 0 losing a collision.
    always_comb begin
        wdrop_d = 1'b0;
        if (ready) begin
            wdrop_d = wen0 && wen1 && (waddr0 == waddr1) && (waddr0 != AW'(RF_ZERO_ADDR));
        end else begin
            wdrop_d = (wen0 && (waddr0 != AW'(RF_ZERO_ADDR))) ||
                      (wen1 && (waddr1 != AW'(RF_ZERO_ADDR)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wdrop_q <= 1'b0;
        else        wdrop_q <= wdrop_d;
    end

    assign wdrop = wdrop_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;

        assign a = raddr[port_lsb(i, AW) +: AW];

        always_comb begin
            d = '0;
            if (state == RF_READY && a != AW'(RF_ZERO_ADDR)) begin
                d = mem_q[a];
`ifdef REGFILE_MP_BYPASS_EN
                if (we0 && waddr0 == a) d = wdata0;
                if (we1 && waddr1 == a) d = wdata1;
`else
`endif
            end
        end

        assign rdata[port_lsb(i, XLEN) +: XLEN] = d;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the TinyRV1 core and its successors. Provides NRD combinational read ports and two synchronous write ports with a fixed port priority. A built-in clear sequencer zeroes every register after reset and reports `ready`, so architectural state is deterministic without relying on FPGA initial values. Sits in the decode/writeback stages: reads are in decode, writes come from writeback (port 0) and a long-latency unit such as mul/div or load return (port 1).

## Interface
Parameters:
- `XLEN`, 32, register width in bits
- `NREGS`, 32, register count; power of two, minimum 4; register 0 hardwired to zero
- `NRD`, 2, number of read ports, 1 to 4
- `AW`, $clog2(NREGS), address width; derived, not overridden

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `ready`  out  1  high once the clear sweep has completed
- `wen0`  in  1  write enable, port 0
- `waddr0`  in  AW  write address, port 0
- `wdata0`  in  XLEN  write data, port 0
- `wen1`  in  1  write enable, port 1
- `waddr1`  in  AW  write address, port 1
- `wdata1`  in  XLEN  write data, port 1
- `raddr`  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- `rdata`  out  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN]
- `wdrop`  out  1  registered one-cycle pulse: at least one enabled, non-zero-address write was discarded in the previous cycle

## Operation
- FSM states: CLEAR, READY.
  - `rst_n`=0 at an edge: state <= CLEAR, clear counter <= 1, `ready` <= 0, `wdrop` <= 0. Register contents are not touched by reset itself.
  - CLEAR: at each edge, R[counter] <= 0 and the counter increments. At the edge that clears R[NREGS-1], state <= READY.
  - READY: stays in READY until the next reset.
- Writes in CLEAR are discarded. An enabled write with a non-zero address sets `wdrop` on the next cycle.
- Writes in READY:
  - Port p with wen_p=1 and waddr_p!=0 writes wdata_p at the edge.
  - If both ports target the same non-zero address, port 1 wins, and `wdrop` pulses on the next cycle.
  - Writes to address 0 are ignored and do not set `wdrop`.
- Reads are combinational.
  - raddr_i==0: rdata_i=0.
  - In CLEAR: every rdata_i=0.
  - In READY: rdata_i=R[raddr_i], before any same-cycle write unless bypass is enabled (see Configuration).
- Reset asserted mid-sweep restarts the sweep from index 1.

## Timing
- `ready` rises NREGS-1 edges after the first edge with `rst_n`=1. For NREGS=32 that is edge 31.
- Write-to-read latency: 1 cycle. Data written at edge k is visible on reads from after edge k onward.
- `wdrop` asserts in the cycle following the offending write and lasts exactly one cycle per event.
- Reset values:
  - `ready`=0, `wdrop`=0
  - FSM in CLEAR
  - `rdata`=0 on all ports while in CLEAR

## Configuration
- `REGFILE_MP_BYPASS_EN` defined: write-to-read forwarding.
  - In READY, if raddr_i!=0 matches an enabled same-cycle write, rdata_i returns that write data combinationally.
  - If both write ports match, port 1 data is returned.
  - Effective latency becomes 0 cycles. No forwarding in CLEAR.
- Undefined: no forwarding; reads return the pre-edge register contents.

## Structure
- Package `regfile_mp_pkg`:
  - state enum `rf_state_e` {RF_CLEAR, RF_READY}
  - `RF_ZERO_ADDR` constant
  - helper for packed-port slicing
- Sub-module `regfile_mp_clear`: CLEAR/READY FSM plus clear counter. Outputs `ready`, `clr_en`, `clr_addr`.
- The top level holds the storage array, write arbitration, read muxes and the `wdrop` register.

## Test plan
- Reset low for 2 cycles, then high: `ready`=0 through edge 30 and =1 at edge 31 (NREGS=32). All reads return 0 throughout.
- After `ready`: write R5=0xDEADBEEF via port 0, then read port 0 raddr=5 on the next cycle -> 0xDEADBEEF. Same-cycle read returns the old value, or 0xDEADBEEF with the bypass macro defined.
- Both ports write address 7 (0x11, 0x22) in the same cycle -> R7=0x22 and `wdrop` pulses for 1 cycle. Write to address 0 -> read 0 and no `wdrop`.
- Write during CLEAR (addr 3, 0x55): `wdrop` pulses. After `ready`, R3 reads 0.
- Fill R1..R31, pulse `rst_n` low for 1 cycle mid-run, then release: all registers read 0 after the 31-edge sweep, and `ready` is low during it.
- NRD=4: four distinct addresses read simultaneously return four independent correct values.
